// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the WISC fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Default PC / address / instruction width of the WISC pipeline
  localparam int PC_W_DEFAULT = 16;

  // Instruction word decode sees when IF/ID holds no real instruction
  localparam logic [15:0] WISC_NOP = 16'h0800;

  // Fetch controller states
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,  // request in flight at pc
    S_HOLD   = 2'd1,  // word parked in hold buffer while decode stalls
    S_DRAIN  = 2'd2,  // stale request outstanding after a redirect
    S_HALTED = 2'd3   // fetch stopped by HALT
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_hold_buf
//  Brief    : One-entry skid register {instr, pc2, full} that parks a fetched
//             word while decode is stalled. clear wins over load, load wins
//             over unload.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_hold_buf #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [PC_W-1:0] instr_in,
  input  logic [PC_W-1:0] pc2_in,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc2,
  output logic            full
);

  // Capture a word on load, release it on unload, drop it on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc2   <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= instr_in;
      pc2   <= pc2_in;
    end else if (unload) begin
      full  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Brief    : Fetch-stage PC register and IF/ID producer for the 16-bit WISC
//             pipeline. Issues requests to a variable-latency instruction
//             memory, parks a word in a one-entry hold buffer on decode
//             stalls, drains stale responses after redirects and stops on
//             HALT.
//  Options  : FETCH_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt outputs.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] NOP_INSTR = PC_W'(WISC_NOP)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_ex,
  input  logic            redirect,
  input  logic            stall,
  input  logic            halt_fetch,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_rdata,
  input  logic            imem_done,
  output logic [PC_W-1:0] if_instr,
  output logic [PC_W-1:0] if_pc2,
  output logic            if_valid,
  output logic            fetch_halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]     fetch_cnt,
  output logic [15:0]     stall_cnt,
`endif
  output logic            misalign_err
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] drain_addr;   // address of the request being drained
  logic [PC_W-1:0] pc_plus2;
  logic            halt_pend;    // HALT seen while a request was in flight

  logic            deliver;      // memory word goes straight into IF/ID
  logic            hb_load;
  logic            hb_unload;
  logic            hb_clear;
  logic            hb_full;
  logic [PC_W-1:0] hb_instr;
  logic [PC_W-1:0] hb_pc2;

  // Wraps modulo 2^PC_W by construction
  assign pc_plus2  = pc + PC_W'(2);

  // A request stays asserted in S_DRAIN so the stale one completes cleanly
  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

  // Route the completing word to IF/ID or the hold buffer; redirect flushes
  always_comb begin
    deliver   = 1'b0;
    hb_load   = 1'b0;
    hb_unload = 1'b0;
    hb_clear  = redirect;
    if (!redirect) begin
      if ((state == S_FETCH) && imem_done) begin
        deliver = !stall;
        hb_load = stall;
      end
      if (((state == S_HOLD) || (state == S_HALTED)) && hb_full && !stall) begin
        hb_unload = 1'b1;
      end
    end
  end

  fetch_hold_buf #(
    .PC_W (PC_W)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (hb_load),
    .unload   (hb_unload),
    .clear    (hb_clear),
    .instr_in (imem_rdata),
    .pc2_in   (pc_plus2),
    .instr    (hb_instr),
    .pc2      (hb_pc2),
    .full     (hb_full)
  );

  // Fetch controller: PC, state, HALT tracking and misalignment flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      drain_addr   <= RESET_PC;
      halt_pend    <= 1'b0;
      fetch_halted <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall and HALT; an unfinished request must be drained
      pc           <= {pc_ex[PC_W-1:1], 1'b0};
      halt_pend    <= 1'b0;
      fetch_halted <= 1'b0;
      if (pc_ex[0]) begin
        misalign_err <= 1'b1;
      end
      state <= S_FETCH;
      if (!imem_done) begin
        if (state == S_FETCH) begin
          state      <= S_DRAIN;
          drain_addr <= pc;
        end else if (state == S_DRAIN) begin
          state <= S_DRAIN;
        end
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_done) begin
            pc <= pc_plus2;
            if (halt_pend || halt_fetch) begin
              state        <= S_HALTED;
              fetch_halted <= 1'b1;
              halt_pend    <= 1'b0;
            end else if (stall) begin
              state <= S_HOLD;
            end
          end else if (halt_fetch) begin
            halt_pend <= 1'b1;
          end
        end
        S_HOLD: begin
          if (halt_fetch) begin
            state        <= S_HALTED;
            fetch_halted <= 1'b1;
          end else if (!stall) begin
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Keep the memory handshake intact: halt only once the stale
          // response has been consumed
          if (imem_done) begin
            if (halt_pend || halt_fetch) begin
              state        <= S_HALTED;
              fetch_halted <= 1'b1;
              halt_pend    <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else if (halt_fetch) begin
            halt_pend <= 1'b1;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // IF/ID register: new word, parked word, bubble, or hold under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc2   <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (deliver) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc2   <= pc_plus2;
    end else if (hb_unload) begin
      if_valid <= 1'b1;
      if_instr <= hb_instr;
      if_pc2   <= hb_pc2;
    end else if (!stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of valid IF/ID writes and lost fetch cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if ((deliver || hb_unload) && (fetch_cnt != 16'hFFFF)) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if ((stall || (imem_req && !imem_done)) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_unit
//  Brief    : Self-checking bench for fetch_pc_unit with a latency-programmable
//             instruction memory and a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_ex;
  logic        redirect;
  logic        stall;
  logic        halt_fetch;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] if_instr;
  logic [15:0] if_pc2;
  logic        if_valid;
  logic        fetch_halted;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_ex        (pc_ex),
    .redirect     (redirect),
    .stall        (stall),
    .halt_fetch   (halt_fetch),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_done    (imem_done),
    .if_instr     (if_instr),
    .if_pc2       (if_pc2),
    .if_valid     (if_valid),
    .fetch_halted (fetch_halted),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .misalign_err (misalign_err)
  );

  // ---------------- instruction memory with programmable latency ----------
  int lat;
  int wcnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hB5A0;
  endfunction

  assign imem_done  = imem_req && (wcnt >= lat - 1);
  assign imem_rdata = imem_done ? mem_word(imem_addr) : 16'hDEAD;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_done) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  // ---------------- reference model ---------------------------------------
  typedef struct packed {
    logic [15:0] pc;
    logic        req;
    logic        stale;
    logic [15:0] stale_addr;
    logic        halted;
    logic        halt_after;
    logic        held;
    logic [15:0] held_addr;
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        mis;
    logic [15:0] fcnt;
    logic [15:0] scnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n            = '0;
    n.req        = 1'b1;
    n.instr      = 16'h0800;
    return n;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic model_t step(input model_t c, input logic r, input logic rd,
                                  input logic [15:0] px, input logic st,
                                  input logic hl, input logic dn);
    model_t n;
    n = c;
    if (r) return model_reset();
    if (st || (c.req && !dn)) n.scnt = sat_inc(c.scnt);
    if (rd) begin
      n.pc         = {px[15:1], 1'b0};
      if (px[0]) n.mis = 1'b1;
      n.v          = 1'b0;
      n.instr      = 16'h0800;
      n.held       = 1'b0;
      n.halted     = 1'b0;
      n.halt_after = 1'b0;
      n.stale      = c.req && !dn;
      n.stale_addr = c.stale ? c.stale_addr : c.pc;
      n.req        = 1'b1;
      return n;
    end
    if (c.req && dn) begin
      if (c.stale) begin
        n.stale = 1'b0;
        if (!st) begin n.v = 1'b0; n.instr = 16'h0800; end
      end else begin
        n.pc = c.pc + 16'd2;
        if (!st) begin
          n.v = 1'b1; n.instr = mem_word(c.pc); n.pc2 = c.pc + 16'd2;
          n.fcnt = sat_inc(c.fcnt);
        end else begin
          n.held = 1'b1; n.held_addr = c.pc;
        end
      end
      if (c.halt_after || hl) begin
        n.halted = 1'b1; n.req = 1'b0; n.halt_after = 1'b0;
      end else if (n.held) begin
        n.req = 1'b0;
      end
    end else if (c.req) begin
      if (!st) begin n.v = 1'b0; n.instr = 16'h0800; end
      if (hl) n.halt_after = 1'b1;
    end else begin
      if (!st) begin
        if (c.held) begin
          n.v = 1'b1; n.instr = mem_word(c.held_addr); n.pc2 = c.held_addr + 16'd2;
          n.held = 1'b0; n.fcnt = sat_inc(c.fcnt);
        end else begin
          n.v = 1'b0; n.instr = 16'h0800;
        end
        if (!c.halted) n.req = 1'b1;
      end
      if (hl && !c.halted) begin n.halted = 1'b1; n.req = 1'b0; end
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, redirect, pc_ex, stall, halt_fetch, imem_done);

  // ---------------- checking ----------------------------------------------
  int checks = 0;
  int fails  = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("m_imem_req", imem_req, m.req);
      chk("m_imem_addr", imem_addr, m.stale ? m.stale_addr : m.pc);
      chk("m_if_valid", if_valid, m.v);
      chk("m_if_instr", if_instr, m.instr);
      if (m.v) chk("m_if_pc2", if_pc2, m.pc2);
      chk("m_fetch_halted", fetch_halted, m.halted);
      chk("m_misalign_err", misalign_err, m.mis);
`ifdef FETCH_PERF_CNT_EN
      chk("m_fetch_cnt", fetch_cnt, m.fcnt);
      chk("m_stall_cnt", stall_cnt, m.scnt);
`endif
    end
  end

  task automatic wait_addr(input logic [15:0] a, input int budget, input string nm);
    int n = 0;
    while (imem_addr !== a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, imem_addr, a);
  endtask

  task automatic wait_flag(input bit want_valid, input int budget, input string nm);
    int n = 0;
    while (((want_valid ? if_valid : fetch_halted) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, want_valid ? if_valid : fetch_halted, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- directed stimulus -------------------------------------
  initial begin
    logic [31:0] pat;
    pat        = 32'hC3A5_96E1;
    rst        = 1'b1;
    redirect   = 1'b0;
    stall      = 1'b0;
    halt_fetch = 1'b0;
    pc_ex      = 16'h0000;
    lat        = 1;
    repeat (2) @(negedge clk);
    armed = 1'b1;

    // Reset state
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 16'h0800);
    chk("rst_pc2", if_pc2, 16'h0000);
    chk("rst_halted", fetch_halted, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);

    // Zero-wait streaming
    rst = 1'b0;
    @(negedge clk);
    chk("zw_instr0", if_instr, 16'hB5A0);
    chk("zw_pc2_0", if_pc2, 16'h0002);
    chk("zw_addr1", imem_addr, 16'h0002);
    @(negedge clk);
    chk("zw_addr2", imem_addr, 16'h0004);
    chk("zw_instr1", if_instr, 16'hB5A2);
    @(negedge clk);
    chk("zw_addr3", imem_addr, 16'h0006);
`ifdef FETCH_PERF_CNT_EN
    chk("zw_fetch_cnt", fetch_cnt, 16'd3);
    chk("zw_stall_cnt", stall_cnt, 16'd0);
`endif

    // Latency 3, stall 5 cycles around the word at 8
    lat = 3;
    wait_addr(16'h0008, 20, "lat3_reach8");
    stall = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_keep_instr", if_instr, 16'hB5A6);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    chk("hold_instr", if_instr, 16'hB5A8);
    chk("hold_pc2", if_pc2, 16'h000A);
    chk("hold_addr", imem_addr, 16'h000A);

    // Redirect while the request to 12 is outstanding
    wait_addr(16'h000C, 20, "lat3_reach12");
    redirect = 1'b1;
    pc_ex    = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    chk("drain_addr", imem_addr, 16'h000C);
    chk("drain_valid", if_valid, 1'b0);
    wait_flag(1'b1, 20, "drain_resume");
    chk("redir_instr", if_instr, 16'hB5E0);
    chk("redir_pc2", if_pc2, 16'h0042);

    // redirect + stall + halt together
    lat        = 1;
    redirect   = 1'b1;
    pc_ex      = 16'h0080;
    stall      = 1'b1;
    halt_fetch = 1'b1;
    @(negedge clk);
    redirect   = 1'b0;
    stall      = 1'b0;
    halt_fetch = 1'b0;
    chk("combo_valid", if_valid, 1'b0);
    chk("combo_halted", fetch_halted, 1'b0);
    chk("combo_addr", imem_addr, 16'h0080);
    @(negedge clk);
    chk("combo_instr", if_instr, 16'hB520);

    // HALT at pc=20 with zero-wait memory
    redirect = 1'b1;
    pc_ex    = 16'h0014;
    @(negedge clk);
    redirect   = 1'b0;
    halt_fetch = 1'b1;
    @(negedge clk);
    halt_fetch = 1'b0;
    chk("halt_last_instr", if_instr, 16'hB5B4);
    chk("halt_flag", fetch_halted, 1'b1);
    repeat (3) @(negedge clk);
    chk("halt_req", imem_req, 1'b0);
    chk("halt_valid", if_valid, 1'b0);
    redirect = 1'b1;
    pc_ex    = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    chk("unhalt_addr", imem_addr, 16'h0100);
    chk("unhalt_flag", fetch_halted, 1'b0);
    @(negedge clk);
    chk("unhalt_instr", if_instr, 16'hB4A0);
    redirect = 1'b1;
    pc_ex    = 16'h0033;
    @(negedge clk);
    redirect = 1'b0;
    chk("misalign_flag", misalign_err, 1'b1);
    chk("misalign_addr", imem_addr, 16'h0032);

    // PC wrap
    redirect = 1'b1;
    pc_ex    = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 16'hFFFE);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 16'h0000);
    chk("wrap_instr", if_instr, 16'h4A5E);
    chk("wrap_pc2", if_pc2, 16'h0000);

    // Mixed stall pattern, latency 2
    lat = 2;
    for (int i = 0; i < 32; i++) begin
      stall = pat[i];
      @(negedge clk);
    end
    stall = 1'b0;
    repeat (4) @(negedge clk);

    // HALT while a latency-3 request is in flight
    lat        = 3;
    halt_fetch = 1'b1;
    @(negedge clk);
    halt_fetch = 1'b0;
    wait_flag(1'b0, 10, "halt_pending_done");
    repeat (2) @(negedge clk);
    redirect = 1'b1;
    pc_ex    = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a request
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_addr", imem_addr, 16'h0000);
    chk("rst2_valid", if_valid, 1'b0);
    chk("rst2_misalign", misalign_err, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_fetch_cnt", fetch_cnt, 16'd0);
    chk("rst2_stall_cnt", stall_cnt, 16'd0);
`endif
    rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
